acc_trace_checker: RTL and testbench
====================================

Name: acc_trace_checker

Overview:
- Synthesizable self-checking harness for the AY8 core; replaces hand-timed `$write` sampling of the accumulator in sims.
- Loads a program image into Memory through a write port, then holds the core in reset until the load completes.
- Releases the core, samples `acc` at a fixed offset and period, and compares each sample against an expected-value table.
- Reports pass/fail, error count and first-failure details; parametrised in data width, program depth, check count and timing.

Parameters:
DATA_W, 8, accumulator/memory word width
PROG_DEPTH, 64, words loaded into Memory (addresses 0..PROG_DEPTH-1)
N_CHECKS, 15, number of acc samples compared
FIRST_SAMPLE, 10, cycles from core release to first sample (>=1)
SAMPLE_PERIOD, 8, cycles between samples (>=1)
ADDR_W, $clog2(PROG_DEPTH), program address width
IDX_W, $clog2(N_CHECKS+1), check index width
CNT_W, IDX_W, error counter width

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse
abort  in  1  stop run immediately
prog_addr  out  ADDR_W  image ROM address (combinational read)
prog_data  in  DATA_W  image ROM data for prog_addr
mem_we  out  1  Memory write enable
mem_addr  out  ADDR_W  Memory write address
mem_wdata  out  DATA_W  Memory write data
core_rst_n  out  1  core/memory-run reset, active-low, registered
acc  in  DATA_W  core accumulator
exp_idx  out  IDX_W  expected-table index (combinational read)
exp_data  in  DATA_W  expected acc for exp_idx
sample_valid  out  1  one-cycle pulse per sample taken
sample_data  out  DATA_W  acc value captured at the sample
busy  out  1  LOAD/WAIT/SAMPLE active
done  out  1  run complete, held until next start
pass  out  1  valid when done: err_count==0
err_count  out  CNT_W  mismatches in this run, saturating
first_err_idx  out  IDX_W  index of first mismatch
first_err_acc  out  DATA_W  acc at first mismatch

Behaviour:
- Reset (`RST`=0, async): state IDLE; `core_rst_n`=0; `mem_we`=0. All counters, `busy`, `done`, `pass`, `err_count`, `first_err_*`, `sample_*` and `exp_idx` are 0.
- States: IDLE -> LOAD -> WAIT -> SAMPLE -> DONE.
- IDLE / DONE: `start`=1 clears `err_count`, `first_err_*`, `done`, `pass` and `exp_idx`, zeroes the address counter, and enters LOAD.
- LOAD: one word per cycle. `mem_we`=1, `mem_addr`=`prog_addr`=counter, `mem_wdata`=`prog_data`. Lasts exactly PROG_DEPTH cycles at addresses 0..PROG_DEPTH-1, then WAIT. `core_rst_n`=0 throughout.
- WAIT:
  - `core_rst_n`=1 from the first WAIT cycle; call that edge t0.
  - The first sample is taken at edge t0+FIRST_SAMPLE-1, i.e. the FIRST_SAMPLE-th cycle with `core_rst_n`=1.
  - Enter SAMPLE at that edge.
- SAMPLE:
  - Sample k (k=0..N_CHECKS-1) is taken at t0+FIRST_SAMPLE-1+k*SAMPLE_PERIOD.
  - On each sample, `acc` is registered into `sample_data` and `sample_valid` pulses for 1 cycle.
  - `acc` is compared against `exp_data` with `exp_idx`=k.
  - On mismatch, `err_count`++ (saturates at 2^CNT_W-1). If this is the first mismatch, `first_err_idx`=k and `first_err_acc`=`acc`.
  - `exp_idx` increments after each sample.
  - After sample N_CHECKS-1, go to DONE on the next edge.
- DONE: `done`=1, `pass`=(`err_count`==0), `busy`=0. `core_rst_n` returns to 0, freezing the core.
- `busy`=1 in LOAD, WAIT and SAMPLE. `start` while busy is ignored.
- `abort`=1 (any state, priority over `start`):
  - Next state IDLE; `mem_we`=0; `core_rst_n`=0; `done`=0; `pass`=0.
  - `err_count` and `first_err_*` keep their values.
- `abort` in the same cycle as a sample edge: the sample is still compared and counted, then IDLE.
- `RST` asserted mid-run: immediate async return to reset values. A partially loaded Memory is not restored.
- The `acc` sample uses the value present before the sampling edge; there is no internal pipeline on `acc`.

Test Plan:
- Defaults; image = AY8 logic-op program (`05 03 01 06 …`); expected table = 07,fb,ff,02,06,fa,fc,01,05,f9,fd,00,04,f8,fc; core behaves -> `mem_we` high 64 cycles at addresses 0..63; 15 `sample_valid` pulses spaced 8 cycles, first 10 cycles after `core_rst_n` rises; `done`=1, `pass`=1, `err_count`=0.
- Same run with expected[3]=0x03 -> `err_count`=1, `first_err_idx`=3, `first_err_acc`=0x02, `pass`=0.
- Expected table all 0xAA, acc never 0xAA -> `err_count`=15, `first_err_idx`=0.
- `start` pulsed again at LOAD cycle 20 and SAMPLE k=5 -> ignored; addresses continue 21..63; run ends after 15 samples.
- `abort` at sample k=7 edge -> sample 7 counted; next cycle IDLE, `core_rst_n`=0, `done`=0. A new `start` then completes normally with `err_count` cleared.
- `RST` low at LOAD address 30 -> same-cycle (async) `mem_we`=0, `core_rst_n`=0, `busy`=0. After release, `start` reloads from address 0.

Source files
------------

// File: rtl/acc_trace_checker.sv
// Self-checking harness for the AY8 core: loads a program image, releases the core,
// samples the accumulator on a fixed schedule and scores it against an expected table.
module acc_trace_checker #(
  parameter int DATA_W        = 8,
  parameter int PROG_DEPTH    = 64,
  parameter int N_CHECKS      = 15,
  parameter int FIRST_SAMPLE  = 10,
  parameter int SAMPLE_PERIOD = 8,
  parameter int ADDR_W        = $clog2(PROG_DEPTH),
  parameter int IDX_W         = $clog2(N_CHECKS + 1),
  parameter int CNT_W         = IDX_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_rst_n,
  input  logic [DATA_W-1:0] acc,
  output logic [IDX_W-1:0]  exp_idx,
  input  logic [DATA_W-1:0] exp_data,
  output logic              sample_valid,
  output logic [DATA_W-1:0] sample_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_acc
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int TMR_MAX   = (FIRST_SAMPLE > SAMPLE_PERIOD) ? FIRST_SAMPLE : SAMPLE_PERIOD;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);
  // WAIT covers the first FIRST_SAMPLE-1 released cycles; the next cycle is sample 0.
  localparam int WAIT_INIT = (FIRST_SAMPLE > 1) ? FIRST_SAMPLE - 2 : 0;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_CHECKS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [TMR_W-1:0]  r_tmr;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [IDX_W-1:0]  r_first_idx;
  logic [DATA_W-1:0] r_first_acc;
  logic [DATA_W-1:0] r_sample_data;
  logic              r_sample_valid;
  logic              r_core_rst_n;
  logic              r_done;
  logic              r_pass;

  logic              w_strobe;
  logic              w_mismatch;
  logic              w_start;
  logic [CNT_W-1:0]  w_err_next;

  // A sample is the SAMPLE-state cycle whose period timer has run out.
  assign w_strobe   = (r_state == S_SAMPLE) && (r_tmr == '0);
  assign w_mismatch = w_strobe && (acc != exp_data);
  assign w_start    = start && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_err_next = r_err_cnt;
    if (w_mismatch && (r_err_cnt != CNT_MAX)) w_err_next = r_err_cnt + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_tmr        <= '0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else if (abort) begin
      r_state      <= S_IDLE;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_addr  <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_LOAD: begin
          r_addr <= r_addr + 1'b1;
          if (r_addr == LAST_ADDR) begin
            r_core_rst_n <= 1'b1;
            r_tmr        <= TMR_W'(WAIT_INIT);
            r_state      <= (FIRST_SAMPLE > 1) ? S_WAIT : S_SAMPLE;
          end
        end
        S_WAIT: begin
          if (r_tmr == '0) r_state <= S_SAMPLE;
          else             r_tmr   <= r_tmr - 1'b1;
        end
        S_SAMPLE: begin
          if (r_tmr == '0) begin
            if (r_idx == LAST_IDX) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_pass       <= (w_err_next == '0);
              r_core_rst_n <= 1'b0;
            end else begin
              r_tmr <= TMR_W'(SAMPLE_PERIOD - 1);
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Scoring is independent of abort: a sample taken on an abort edge still counts.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sample_valid <= 1'b0;
      r_sample_data  <= '0;
      r_idx          <= '0;
      r_err_cnt      <= '0;
      r_first_idx    <= '0;
      r_first_acc    <= '0;
    end else begin
      r_sample_valid <= w_strobe;
      if (w_strobe) begin
        r_sample_data <= acc;
        r_idx         <= r_idx + 1'b1;
        r_err_cnt     <= w_err_next;
        if (w_mismatch && (r_err_cnt == '0)) begin
          r_first_idx <= r_idx;
          r_first_acc <= acc;
        end
      end else if (w_start) begin
        r_idx       <= '0;
        r_err_cnt   <= '0;
        r_first_idx <= '0;
        r_first_acc <= '0;
      end
    end
  end

  assign prog_addr     = r_addr;
  assign mem_addr      = r_addr;
  assign mem_wdata     = prog_data;
  assign mem_we        = (r_state == S_LOAD);
  assign busy          = (r_state == S_LOAD) || (r_state == S_WAIT) || (r_state == S_SAMPLE);
  assign core_rst_n    = r_core_rst_n;
  assign exp_idx       = r_idx;
  assign sample_valid  = r_sample_valid;
  assign sample_data   = r_sample_data;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err_cnt;
  assign first_err_idx = r_first_idx;
  assign first_err_acc = r_first_acc;

endmodule

// File: tb/tb_acc_trace_checker.sv
// Scoreboard bench for acc_trace_checker: a stand-in core replays a random acc trace,
// expected samples are queued at start and a monitor pops and scores each sample_valid.
module tb_acc_trace_checker;

  localparam int DATA_W     = 8;
  localparam int PROG_DEPTH = 64;
  localparam int N_CHECKS   = 15;
  localparam int FS         = 10;
  localparam int SP         = 8;
  localparam int ADDR_W     = $clog2(PROG_DEPTH);
  localparam int IDX_W      = $clog2(N_CHECKS + 1);
  localparam int CNT_W      = IDX_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              core_rst_n;
  logic [DATA_W-1:0] acc;
  logic [IDX_W-1:0]  exp_idx;
  logic [DATA_W-1:0] exp_data;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              busy, done, pass;
  logic [CNT_W-1:0]  err_count;
  logic [IDX_W-1:0]  first_err_idx;
  logic [DATA_W-1:0] first_err_acc;

  always #5 clk = ~clk;

  acc_trace_checker #(
    .DATA_W(DATA_W), .PROG_DEPTH(PROG_DEPTH), .N_CHECKS(N_CHECKS),
    .FIRST_SAMPLE(FS), .SAMPLE_PERIOD(SP)
  ) dut (
    .CLK(clk), .RST(rst_n), .start(start), .abort(abort),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n), .acc(acc),
    .exp_idx(exp_idx), .exp_data(exp_data),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_acc(first_err_acc)
  );

  logic [7:0] image     [PROG_DEPTH];
  logic [7:0] mem_model [PROG_DEPTH];
  logic [7:0] trace     [256];
  logic [7:0] exp_tab   [16];
  logic [7:0] spec_tab  [N_CHECKS] = '{8'h07, 8'hfb, 8'hff, 8'h02, 8'h06, 8'hfa, 8'hfc, 8'h01,
                                       8'h05, 8'hf9, 8'hfd, 8'h00, 8'h04, 8'hf8, 8'hfc};

  assign prog_data = image[prog_addr];
  assign exp_data  = exp_tab[exp_idx];

  // Stand-in core: acc replays trace[n] during the n-th cycle after release.
  logic [7:0] core_cnt;
  always @(posedge clk) begin
    if (!core_rst_n)            core_cnt <= 8'd0;
    else if (core_cnt != 8'hff) core_cnt <= core_cnt + 8'd1;
  end
  assign acc = trace[core_cnt];

  typedef struct {
    logic [7:0] data;
    int         off;
  } samp_t;
  samp_t sq[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: load-port sequence, memory image capture and sample scoreboard.
  int   cyc = 0;
  int   n0 = 0;
  int   next_addr = 0;
  logic prev_crn = 1'b0;
  always @(negedge clk) begin
    samp_t s;
    cyc++;
    if (core_rst_n && !prev_crn) n0 = cyc;
    prev_crn = core_rst_n;
    if (!busy) next_addr = 0;
    if (mem_we) begin
      check("mem_addr_seq", 32'(mem_addr), 32'(next_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(image[mem_addr]));
      mem_model[mem_addr] = mem_wdata;
      next_addr++;
    end
    if (sample_valid) begin
      if (sq.size() == 0) begin
        check("sample_unexpected", 32'(sample_valid), 32'd0);
      end else begin
        s = sq.pop_front();
        check("sample_data", 32'(sample_data), 32'(s.data));
        check("sample_offset", 32'(cyc - n0), 32'(s.off));
      end
    end
  end

  task automatic setup_trace(input bit aa_free);
    for (int i = 0; i < 256; i++) begin
      trace[i] = 8'($urandom);
      while (aa_free && trace[i] == 8'hAA) trace[i] = 8'($urandom);
    end
    for (int k = 0; k < N_CHECKS; k++) begin
      trace[FS - 1 + k * SP] = spec_tab[k];
      exp_tab[k]             = spec_tab[k];
    end
    exp_tab[15] = 8'h00;
  endtask

  task automatic push_samples(input int n);
    for (int k = 0; k < n; k++) sq.push_back('{data: trace[FS - 1 + k * SP], off: FS + k * SP});
  endtask

  task automatic ref_score(input int n, output int errs, output int fidx, output int facc);
    errs = 0; fidx = 0; facc = 0;
    for (int k = 0; k < n; k++) begin
      if (trace[FS - 1 + k * SP] != exp_tab[k]) begin
        if (errs == 0) begin
          fidx = k;
          facc = trace[FS - 1 + k * SP];
        end
        errs++;
      end
    end
    if (errs > (1 << CNT_W) - 1) errs = (1 << CNT_W) - 1;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done();
    int b = 0;
    while (!done && b < 2000) begin
      @(negedge clk);
      b++;
    end
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic wait_addr(input int a);
    int b = 0;
    while (!(mem_we && mem_addr == ADDR_W'(a)) && b < 500) begin
      @(negedge clk);
      b++;
    end
    check("load_addr_reached", 32'(mem_we && mem_addr == ADDR_W'(a)), 32'd1);
  endtask

  task automatic wait_samples(input int n);
    int b = 0;
    int seen = 0;
    while (seen < n && b < 2000) begin
      @(negedge clk);
      b++;
      if (sample_valid) seen++;
    end
    check("samples_reached", 32'(seen), 32'(n));
  endtask

  task automatic check_end(input int n);
    int errs, fidx, facc;
    @(negedge clk);
    ref_score(n, errs, fidx, facc);
    check("end_done", 32'(done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_core_rst_n", 32'(core_rst_n), 32'd0);
    check("end_err_count", 32'(err_count), 32'(errs));
    check("end_pass", 32'(pass), 32'(errs == 0));
    check("end_first_err_idx", 32'(first_err_idx), 32'(fidx));
    check("end_first_err_acc", 32'(first_err_acc), 32'(facc));
    check("end_queue_empty", 32'(sq.size()), 32'd0);
  endtask

  task automatic full_run();
    push_samples(N_CHECKS);
    pulse_start();
    wait_done();
    check_end(N_CHECKS);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs, fidx, facc, mism;
    for (int i = 0; i < PROG_DEPTH; i++) image[i] = 8'($urandom);
    image[0] = 8'h05; image[1] = 8'h03; image[2] = 8'h01; image[3] = 8'h06;
    setup_trace(1'b0);

    repeat (3) @(negedge clk);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_exp_idx", 32'(exp_idx), 32'd0);
    rst_n = 1'b1;

    // Clean run with the logic-op trace, then the image must be in memory.
    full_run();
    mism = 0;
    for (int i = 0; i < PROG_DEPTH; i++) if (mem_model[i] !== image[i]) mism++;
    check("mem_image", 32'(mism), 32'd0);

    // Single bad entry.
    exp_tab[3] = 8'h03;
    full_run();

    // Table that never matches.
    setup_trace(1'b1);
    for (int k = 0; k < 16; k++) exp_tab[k] = 8'hAA;
    full_run();

    // Start pulses while busy are ignored.
    setup_trace(1'b0);
    push_samples(N_CHECKS);
    pulse_start();
    wait_addr(20);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_samples(6);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();
    check_end(N_CHECKS);

    // Abort on the sample-7 edge: sample 7 still counts, then idle.
    setup_trace(1'b0);
    exp_tab[2] = 8'h55;
    exp_tab[9] = 8'h11;
    push_samples(8);
    pulse_start();
    wait_samples(7);
    repeat (SP - 1) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    ref_score(8, errs, fidx, facc);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_core_rst_n", 32'(core_rst_n), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_pass", 32'(pass), 32'd0);
    check("abort_err_count", 32'(err_count), 32'(errs));
    check("abort_first_err_idx", 32'(first_err_idx), 32'(fidx));
    check("abort_first_err_acc", 32'(first_err_acc), 32'(facc));
    @(negedge clk);
    check("abort_queue_empty", 32'(sq.size()), 32'd0);
    setup_trace(1'b0);
    full_run();

    // Async reset mid-load, then a fresh load from address 0.
    pulse_start();
    wait_addr(30);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_we", 32'(mem_we), 32'd0);
    check("arst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_err_count", 32'(err_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < PROG_DEPTH; i++) image[i] = 8'($urandom);
    full_run();
    mism = 0;
    for (int i = 0; i < PROG_DEPTH; i++) if (mem_model[i] !== image[i]) mism++;
    check("mem_image_reload", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
